// File: rtl/window_3x3_gen.sv
// ---------------------------------------------------------------------------
// window_3x3_gen
//
// Turns a raster-order pixel stream into a stream of zero-padded 3x3
// neighbourhood windows, one per pixel of the frame, in raster order of the
// window centre.
//
// The incoming stream is held in two line buffers (the previous row and the
// row before that, indexed by column) and a 3x3 register array that shifts
// one column left per pixel. After the pixel at linear index n is shifted in,
// the array holds the window whose centre is at index n-Img_W-1. The array is
// never cleared. Elements whose coordinates fall outside the frame are forced
// to zero using the centre coordinates, so stale data from a previous frame
// or from wrapped columns can never reach the output.
//
// The last Img_W+1 windows need pixels beyond the end of the frame. The FLUSH
// state produces them by shifting in zeros, one per cycle, while input is
// stalled.
//
// Ports
//   clk          in   single clock, rising edge
//   reset        in   synchronous active-high reset
//   in_img_data  in   Datawidth   raster-order pixel (row 0, col 0 first)
//   img_valid    in   1           in_img_data valid this cycle
//   in_ready     out  1           pixel accepted when img_valid && in_ready
//   win_data     out  9*Datawidth window, element k=3*i+j at [k*Datawidth +: Datawidth]
//   win_valid    out  1           win_data / win_row / win_col valid
//   win_row      out  clog2(Img_H) centre row of the window
//   win_col      out  clog2(Img_W) centre column of the window
//   frame_done   out  1           pulses with the last window of a frame
// ---------------------------------------------------------------------------
module window_3x3_gen #(
  parameter int Datawidth = 8,
  parameter int Img_W     = 512,
  parameter int Img_H     = 512
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [Datawidth-1:0]          in_img_data,
  input  logic                          img_valid,
  output logic                          in_ready,
  output logic [9*Datawidth-1:0]        win_data,
  output logic                          win_valid,
  output logic [$clog2(Img_H)-1:0]      win_row,
  output logic [$clog2(Img_W)-1:0]      win_col,
  output logic                          frame_done
);

  localparam int RW = $clog2(Img_H);
  localparam int CW = $clog2(Img_W);

  localparam logic [RW-1:0] LAST_ROW = RW'(Img_H - 1);
  localparam logic [CW-1:0] LAST_COL = CW'(Img_W - 1);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    RUN,
    FLUSH
  } state_t;

  state_t state;

  // Position of the next pixel to be shifted in (row wraps freely during
  // FLUSH; only the column is used there, to address the line buffers).
  logic [RW-1:0] in_row;
  logic [CW-1:0] in_col;

  // Centre of the next window to be emitted.
  logic [RW-1:0] cen_row;
  logic [CW-1:0] cen_col;

  // Line buffers: lb_a holds the row above the incoming pixel, lb_b the row
  // above that. Both are indexed by column.
  logic [Datawidth-1:0] lb_a [Img_W];
  logic [Datawidth-1:0] lb_b [Img_W];

  // Raw window array [row][col], unmasked.
  logic [Datawidth-1:0] arr      [3][3];
  logic [Datawidth-1:0] next_arr [3][3];

  logic                 shift_en;
  logic                 emit;
  logic                 fill_done;
  logic                 in_last;
  logic                 cen_last;
  logic [Datawidth-1:0] new_pix;
  logic [2:0]           row_ok;
  logic [2:0]           col_ok;
  logic [9*Datawidth-1:0] win_next;

  // -------------------------------------------------------------------------
  // Control decode
  // -------------------------------------------------------------------------
  // In FLUSH the array advances every cycle with a zero pixel; otherwise it
  // advances only on an accepted pixel. in_ready is low exactly in FLUSH.
  assign shift_en  = (state == FLUSH) || (img_valid && in_ready);
  assign new_pix   = (state == FLUSH) ? '0 : in_img_data;

  // Accepting linear index Img_W+1 (row 1, col 1) produces the first window.
  assign fill_done = (in_row == RW'(1)) && (in_col == CW'(1));
  assign in_last   = (in_row == LAST_ROW) && (in_col == LAST_COL);
  assign cen_last  = (cen_row == LAST_ROW) && (cen_col == LAST_COL);

  always_comb begin
    emit = 1'b0;
    if (shift_en) begin
      unique case (state)
        FILL:       emit = fill_done;
        RUN, FLUSH: emit = 1'b1;
        default:    emit = 1'b0;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Next window array: shift one column left, new column enters on the right
  // (top = two rows up, middle = one row up, bottom = incoming pixel).
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a value on every path first, so no
    // latch can be inferred even if a branch below is later edited.
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        next_arr[i][j] = '0;
      end
    end
    for (int i = 0; i < 3; i++) begin
      next_arr[i][0] = arr[i][1];
      next_arr[i][1] = arr[i][2];
    end
    next_arr[0][2] = lb_b[in_col];
    next_arr[1][2] = lb_a[in_col];
    next_arr[2][2] = new_pix;
  end

  // -------------------------------------------------------------------------
  // Zero padding by coordinate masking around the centre being emitted.
  // -------------------------------------------------------------------------
  always_comb begin
    row_ok   = {cen_row != LAST_ROW, 1'b1, cen_row != '0};
    col_ok   = {cen_col != LAST_COL, 1'b1, cen_col != '0};
    win_next = '0;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        if (row_ok[i] && col_ok[j]) begin
          win_next[(3*i+j)*Datawidth +: Datawidth] = next_arr[i][j];
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Storage datapath
  // -------------------------------------------------------------------------
  // NOTE: line buffers and the raw array have no reset; out-of-frame contents
  // are always masked, so clearing them would buy nothing.
  always_ff @(posedge clk) begin
    if (shift_en) begin
      lb_b[in_col] <= lb_a[in_col];
      lb_a[in_col] <= new_pix;
      arr          <= next_arr;
    end
  end

  // -------------------------------------------------------------------------
  // Control FSM and registered outputs
  // -------------------------------------------------------------------------
  // NOTE: all state here uses non-blocking assignments so every register sees
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      in_row     <= '0;
      in_col     <= '0;
      cen_row    <= '0;
      cen_col    <= '0;
      in_ready   <= 1'b1;
      win_valid  <= 1'b0;
      frame_done <= 1'b0;
      win_data   <= '0;
      win_row    <= '0;
      win_col    <= '0;
    end else begin
      win_valid  <= emit;
      frame_done <= emit && cen_last;

      // Outputs hold their last value while no window is emitted.
      if (emit) begin
        win_data <= win_next;
        win_row  <= cen_row;
        win_col  <= cen_col;
        if (cen_col == LAST_COL) begin
          cen_col <= '0;
          cen_row <= (cen_row == LAST_ROW) ? '0 : cen_row + RW'(1);
        end else begin
          cen_col <= cen_col + CW'(1);
        end
      end

      if (shift_en) begin
        if (in_col == LAST_COL) begin
          in_col <= '0;
          in_row <= (in_row == LAST_ROW) ? '0 : in_row + RW'(1);
        end else begin
          in_col <= in_col + CW'(1);
        end
      end

      unique case (state)
        IDLE: begin
          if (shift_en) begin
            state <= FILL;
          end
        end

        FILL: begin
          if (shift_en && fill_done) begin
            state <= RUN;
          end
        end

        RUN: begin
          if (shift_en && in_last) begin
            state    <= FLUSH;
            in_ready <= 1'b0;
          end
        end

        FLUSH: begin
          // The window for the bottom-right centre is emitted on this edge;
          // restart position tracking for the next frame.
          if (cen_last) begin
            state    <= IDLE;
            in_ready <= 1'b1;
            in_row   <= '0;
            in_col   <= '0;
            cen_row  <= '0;
            cen_col  <= '0;
          end
        end

        default: begin
          state    <= IDLE;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_window_3x3_gen.sv
// ---------------------------------------------------------------------------
// tb_window_3x3_gen
//
// Directed sequence on a 4x4 frame: reset state, a continuous frame of
// index+1, the same frame with img_valid toggling, a random frame with random
// gaps, a reset mid-frame followed by a fresh frame, and two frames sent
// back to back. Expected windows come from a direct coordinate-based model of
// the zero-padded neighbourhood; a few windows are also compared against
// hand-computed constants.
// ---------------------------------------------------------------------------
module tb_window_3x3_gen;

  localparam int DW = 8;
  localparam int W  = 4;
  localparam int H  = 4;
  localparam int NP = W * H;

  logic            clk;
  logic            reset;
  logic [DW-1:0]   in_img_data;
  logic            img_valid;
  logic            in_ready;
  logic [9*DW-1:0] win_data;
  logic            win_valid;
  logic [1:0]      win_row;
  logic [1:0]      win_col;
  logic            frame_done;

  window_3x3_gen #(.Datawidth(DW), .Img_W(W), .Img_H(H)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_img_data (in_img_data),
    .img_valid   (img_valid),
    .in_ready    (in_ready),
    .win_data    (win_data),
    .win_valid   (win_valid),
    .win_row     (win_row),
    .win_col     (win_col),
    .frame_done  (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [9*DW-1:0] data;
    logic [1:0]      row;
    logic [1:0]      col;
    logic            fd;
    int              stamp;
  } win_t;

  win_t            wq[$];
  int              checks    = 0;
  int              failures  = 0;
  int              cyc       = 0;
  int              fd_count  = 0;
  int              ready_low = 0;
  int              spurious  = 0;
  int              hold_err  = 0;
  logic            acc_q     = 1'b0;
  logic            flush_q   = 1'b0;
  logic            rst_q     = 1'b1;
  logic [9*DW-1:0] prev_data = '0;
  int              acc_stamp [2][NP];
  logic [9*DW-1:0] got [NP];

  // Edge bookkeeping: was a pixel accepted / a flush step taken at this edge.
  always @(posedge clk) begin
    cyc     <= cyc + 1;
    acc_q   <= img_valid && in_ready;
    flush_q <= !in_ready;
    rst_q   <= reset;
  end

  // Output monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (win_valid) wq.push_back('{win_data, win_row, win_col, frame_done, cyc});
    if (frame_done) fd_count++;
    if (!in_ready) ready_low++;
    if (win_valid && !acc_q && !flush_q) spurious++;
    if (frame_done && !win_valid) spurious++;
    if (!win_valid && !rst_q && win_data !== prev_data) hold_err++;
    prev_data = win_data;
  end

  task automatic check(input string tag, input logic [9*DW-1:0] obs, input logic [9*DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [9*DW-1:0] pack9(input int v0, input int v1, input int v2,
                                            input int v3, input int v4, input int v5,
                                            input int v6, input int v7, input int v8);
    logic [9*DW-1:0] w;
    w = {DW'(v8), DW'(v7), DW'(v6), DW'(v5), DW'(v4), DW'(v3), DW'(v2), DW'(v1), DW'(v0)};
    return w;
  endfunction

  // Zero-padded neighbourhood of centre index m, straight from coordinates.
  function automatic logic [9*DW-1:0] model_win(input logic [DW-1:0] px [NP], input int m);
    logic [9*DW-1:0] w;
    int r;
    int c;
    w = '0;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        r = m / W + i - 1;
        c = m % W + j - 1;
        if (r >= 0 && r < H && c >= 0 && c < W) w[(3*i+j)*DW +: DW] = px[r*W+c];
      end
    end
    return w;
  endfunction

  task automatic accept(input logic [DW-1:0] v, output int stamp);
    logic rdy;
    int   n;
    n = 0;
    img_valid   = 1'b1;
    in_img_data = v;
    do begin
      rdy = in_ready;
      @(posedge clk); #1;
      n++;
    end while (!rdy && n < 100);
    stamp = cyc;
    if (!rdy) check("accept_timeout", 0, 1);
  endtask

  // gap_mode: 0 continuous, 1 one idle cycle after each pixel, 2 random 0..2.
  task automatic run_frame(input logic [DW-1:0] px [NP], input int npix, input int gap_mode,
                           input int slot, input bit junk);
    int st;
    int gap;
    int n;
    for (int p = 0; p < npix; p++) begin
      accept(px[p], st);
      acc_stamp[slot][p] = st;
      gap = (gap_mode == 1) ? 1 : (gap_mode == 2) ? int'($urandom_range(0, 2)) : 0;
      if (p != npix - 1) begin
        for (int g = 0; g < gap; g++) begin
          img_valid   = 1'b0;
          in_img_data = DW'($urandom);
          @(posedge clk); #1;
        end
      end
    end
    // Keep img_valid high with junk while the block flushes.
    if (junk) begin
      n = 0;
      img_valid = 1'b1;
      do begin
        in_img_data = DW'($urandom);
        @(posedge clk); #1;
        n++;
      end while (!in_ready && n < 50);
    end
    img_valid = 1'b0;
  endtask

  task automatic wait_fd(input int target);
    int n;
    n = 0;
    while (fd_count < target && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    check("frame_done_timeout", 72'(fd_count >= target), 72'(1));
  endtask

  task automatic check_frame(input logic [DW-1:0] px [NP], input int slot, input string tag);
    win_t w;
    int   exp_st;
    for (int m = 0; m < NP; m++) begin
      if (wq.size() == 0) begin
        check($sformatf("%s_missing_win%0d", tag, m), 0, 1);
        break;
      end
      w = wq.pop_front();
      got[m] = w.data;
      exp_st = (m <= NP - W - 2) ? acc_stamp[slot][m + W + 1]
                                 : acc_stamp[slot][NP - 1] + (m - (NP - W - 2));
      check($sformatf("%s_data%0d", tag, m), w.data, model_win(px, m));
      check($sformatf("%s_row%0d", tag, m), 72'(w.row), 72'(m / W));
      check($sformatf("%s_col%0d", tag, m), 72'(w.col), 72'(m % W));
      check($sformatf("%s_fd%0d", tag, m), 72'(w.fd), 72'(m == NP - 1));
      check($sformatf("%s_time%0d", tag, m), 72'(w.stamp), 72'(exp_st));
    end
  endtask

  logic [DW-1:0] fa [NP];
  logic [DW-1:0] fb [NP];
  int            fd_base;
  int            rl_base;

  initial begin
    reset       = 1'b1;
    img_valid   = 1'b0;
    in_img_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_win_valid", 72'(win_valid), 72'(0));
    check("rst_win_data", win_data, 72'(0));
    check("rst_win_row", 72'(win_row), 72'(0));
    check("rst_win_col", 72'(win_col), 72'(0));
    check("rst_frame_done", 72'(frame_done), 72'(0));
    check("rst_in_ready", 72'(in_ready), 72'(1));
    reset = 1'b0;
    @(posedge clk); #1;

    // Frame 1: index+1, continuous, junk on img_valid during flush.
    for (int p = 0; p < NP; p++) fa[p] = DW'(p + 1);
    fd_base = fd_count;
    rl_base = ready_low;
    run_frame(fa, NP, 0, 0, 1'b1);
    wait_fd(fd_base + 1);
    check_frame(fa, 0, "f1");
    check("f1_c00", got[0], pack9(0, 0, 0, 0, 1, 2, 0, 5, 6));
    check("f1_c11", got[5], pack9(1, 2, 3, 5, 6, 7, 9, 10, 11));
    check("f1_c33", got[15], pack9(11, 12, 0, 15, 16, 0, 0, 0, 0));
    check("f1_ready_low", 72'(ready_low - rl_base), 72'(W + 1));
    check("f1_in_ready_after", 72'(in_ready), 72'(1));

    // Frame 2: same pixels, img_valid toggling.
    fd_base = fd_count;
    rl_base = ready_low;
    run_frame(fa, NP, 1, 0, 1'b0);
    wait_fd(fd_base + 1);
    check_frame(fa, 0, "f2");
    check("f2_ready_low", 72'(ready_low - rl_base), 72'(W + 1));

    // Frame 3: random pixels, random gaps.
    for (int p = 0; p < NP; p++) fa[p] = DW'($urandom);
    fd_base = fd_count;
    run_frame(fa, NP, 2, 0, 1'b1);
    wait_fd(fd_base + 1);
    check_frame(fa, 0, "f3");

    // Reset after 9 pixels, then a fresh frame of 100+index.
    for (int p = 0; p < NP; p++) fa[p] = DW'($urandom);
    run_frame(fa, 9, 0, 0, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("abort_win_count", 72'(wq.size()), 72'(9 - W - 1));
    check("abort_win_valid", 72'(win_valid), 72'(0));
    check("abort_win_data", win_data, 72'(0));
    check("abort_win_pos", 72'({win_row, win_col}), 72'(0));
    check("abort_in_ready", 72'(in_ready), 72'(1));
    wq.delete();
    for (int p = 0; p < NP; p++) fb[p] = DW'(100 + p);
    fd_base = fd_count;
    run_frame(fb, NP, 0, 0, 1'b0);
    wait_fd(fd_base + 1);
    check_frame(fb, 0, "f4");
    check("f4_c00", got[0], pack9(0, 0, 0, 0, 100, 101, 0, 104, 105));

    // Two frames back to back: random, then 200+index.
    for (int p = 0; p < NP; p++) begin
      fa[p] = DW'($urandom);
      fb[p] = DW'(200 + p);
    end
    fd_base = fd_count;
    rl_base = ready_low;
    run_frame(fa, NP, 0, 0, 1'b0);
    run_frame(fb, NP, 0, 1, 1'b0);
    wait_fd(fd_base + 2);
    check_frame(fa, 0, "b2b_a");
    check_frame(fb, 1, "b2b_b");
    check("b2b_c00", got[0], pack9(0, 0, 0, 0, 200, 201, 0, 204, 205));
    check("b2b_fd_pulses", 72'(fd_count - fd_base), 72'(2));
    check("b2b_ready_low", 72'(ready_low - rl_base), 72'(2 * (W + 1)));

    repeat (4) @(posedge clk);
    #1;
    check("no_extra_windows", 72'(wq.size()), 72'(0));
    check("no_unprompted_windows", 72'(spurious), 72'(0));
    check("data_held_when_idle", 72'(hold_err), 72'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/window_3x3_gen.md
WINDOW_3X3_GEN -- requirements
Module: window_3x3_gen

Interface
REQ-001 The block SHALL have parameter Datawidth, default 8, meaning pixel width in bits.
REQ-002 The block SHALL have parameter Img_W, default 512, meaning pixels per row (min 3).
REQ-003 The block SHALL have parameter Img_H, default 512, meaning rows per frame (min 3).
REQ-004 The block SHALL have port clk  input  1  meaning the single clock; all logic on rising edge.
REQ-005 The block SHALL have port reset  input  1  meaning synchronous, active-high reset.
REQ-006 The block SHALL have port in_img_data  input  Datawidth  meaning raster-order pixel, row 0 col 0 first.
REQ-007 The block SHALL have port img_valid  input  1  meaning in_img_data valid this cycle.
REQ-008 The block SHALL have port in_ready  output  1  meaning pixel accepted when img_valid && in_ready.
REQ-009 The block SHALL have port win_data  output  9*Datawidth  meaning 3x3 window; element k=3*i+j at bits [k*Datawidth +: Datawidth], i=row (0 top), j=col (0 left).
REQ-010 The block SHALL have port win_valid  output  1  meaning win_data, win_row, win_col valid this cycle.
REQ-011 The block SHALL have port win_row  output  clog2(Img_H)  meaning centre row of window.
REQ-012 The block SHALL have port win_col  output  clog2(Img_W)  meaning centre column of window.
REQ-013 The block SHALL have port frame_done  output  1  meaning one-cycle pulse with the last window of a frame.

Function
REQ-014 Window for centre (r,c) SHALL hold pixel(r+i-1, c+j-1) at element (i,j), 0 where that coordinate is outside the frame (zero padding).
REQ-015 Exactly Img_W*Img_H windows SHALL be emitted per frame, in raster order of centre.
REQ-016 Storage SHALL be two line buffers of Img_W entries plus a 3x3 register array; padding SHALL be applied by coordinate masking, so buffers never need clearing.
REQ-017 States SHALL be IDLE, FILL, RUN, FLUSH.
REQ-018 IDLE: in_ready=1; first accepted pixel -> FILL (accepted count 1).
REQ-019 FILL: in_ready=1; no windows; when accepted count reaches Img_W+2 -> RUN.
REQ-020 Accepting pixel of linear index n=Img_W+1+m (FILL exit or RUN) SHALL emit window for centre index m on the next cycle (latency 1 cycle, registered outputs).
REQ-021 RUN: one window per accepted pixel; img_valid gaps SHALL produce win_valid=0 with no state loss.
REQ-022 Acceptance of pixel index Img_W*Img_H-1 SHALL enter FLUSH next cycle.
REQ-023 FLUSH: in_ready=0; exactly Img_W+1 consecutive cycles each emit one window (centres Img_W*Img_H-Img_W-1 .. Img_W*Img_H-1) with zero shifted in; img_valid ignored.
REQ-024 frame_done SHALL assert with the window for centre (Img_H-1, Img_W-1); next cycle state IDLE, in_ready=1.
REQ-025 Back-to-back frames SHALL be supported with one-cycle minimum gap (the IDLE cycle after FLUSH); no data from the prior frame SHALL appear in the new frame's windows.
REQ-026 win_data SHALL hold its last value while win_valid=0.

Reset
REQ-027 reset SHALL force state IDLE, all counters 0, win_valid=0, frame_done=0, win_data=0, win_row=0, win_col=0, in_ready=1 on the next edge.
REQ-028 reset mid-frame (any state) SHALL abandon the frame; the next accepted pixel is row 0 col 0; no partial windows emitted.

Verification (Img_W=4, Img_H=4, pixel value = index+1)
REQ-029 Continuous 16 pixels -> first win_valid the cycle after pixel 6 accepted; centre (0,0) win_data elements k0..k8 = 0,0,0,0,1,2,0,5,6.
REQ-030 Same stream -> centre (1,1) = 1,2,3,5,6,7,9,10,11; centre (3,3) = 11,12,0,15,16,0,0,0,0 with frame_done=1; total 16 windows.
REQ-031 After pixel 16 -> in_ready=0 for exactly 5 cycles, 5 windows emitted; img_valid=1 during FLUSH has no effect.
REQ-032 img_valid toggling 1/0 every cycle -> identical window sequence, win_valid only on cycles after acceptances.
REQ-033 reset asserted after pixel 9 -> outputs zero; then a fresh 16-pixel frame of value 100+index yields centre (0,0) = 0,0,0,0,100,101,0,104,105.
REQ-034 Two frames back-to-back (second values 200+index) -> 32 windows, two frame_done pulses, centre (0,0) of frame 2 = 0,0,0,0,200,201,0,204,205.
